// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo engine: parity modes, FSM encodings, parity helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop
    } rx_state_e;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_e;

    // Parity bit that gives data^bit == 1 (odd) or == 0 (even); unused data bits must be zero.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned ptype);
        if (ptype == PAR_ODD) begin
            return ~(^data);
        end
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Status, read data and pointer advance
    always_comb begin
        count_o  = wr_ptr_q - rd_ptr_q;
        full_o   = (count_o == (AW + 1)'(DEPTH));
        empty_o  = (wr_ptr_q == rd_ptr_q);
        dout_o   = mem_q[rd_ptr_q[AW-1:0]];
        pop_ok   = pop_i && !empty_o;
        // A full FIFO still takes a push when the same cycle pops
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
    end

    // Pointer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written on accepted push
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/uart_fifo_echo.sv
// UART echo engine: RX frames are checked, good bytes buffered, and retransmitted on TX.
module uart_fifo_echo
    import uart_pkg::*;
#(
    parameter int unsigned FREQ       = 50000000,
    parameter int unsigned BPS        = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic                          uart_rxd,
    output logic                          uart_txd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int unsigned CLKS_PER_BIT = FREQ / BPS;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BitMax     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfMax    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LastBit    = 3'(DATA_BITS - 1);
    localparam logic          StopLast   = 1'(STOP_BITS - 1);
    localparam bit            HasParity  = (PARITY != PAR_NONE);

    // ---------------- RX ----------------
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_par_q, rx_par_d;
    logic            rx_done;

    // ---------------- FIFO ----------------
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_dout;
    logic            rx_good;

    // ---------------- TX ----------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic            tx_stop_q, tx_stop_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_par_q, tx_par_d;
    logic            txd_q, txd_d;
    logic            tx_load;

    // Synchroniser and RX state registers
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            rx_par_q   <= rx_par_d;
        end
    end

    // RX next state: start on a synchronised falling edge only, so a held-low line is ignored
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        rx_par_d   = rx_par_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfMax) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxData;
                        rx_bit_d   = '0;
                        rx_data_d  = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxData: begin
                if (rx_cnt_q == BitMax) begin
                    rx_cnt_d            = '0;
                    rx_data_d[rx_bit_q] = rx_s2_q;
                    if (rx_bit_q == LastBit) begin
                        rx_state_d = HasParity ? RxParity : RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxParity: begin
                if (rx_cnt_q == BitMax) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s2_q;
                    rx_state_d = RxStop;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitMax) begin
                    rx_cnt_d   = '0;
                    rx_done    = 1'b1;
                    rx_state_d = RxIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // Error classification at stop sample; exactly one outcome per received frame
    always_comb begin
        frame_err  = rx_done && !rx_s2_q;
        parity_err = rx_done && rx_s2_q && HasParity &&
                     (rx_par_q != parity_bit(rx_data_q, PARITY));
        rx_good    = rx_done && rx_s2_q && !parity_err;
        overflow   = rx_good && fifo_full && !fifo_pop;
        fifo_push  = rx_good && (!fifo_full || fifo_pop);
    end

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (sys_rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (rx_data_q),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // TX state registers; line output is registered and idles high
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    // TX next state: a word is popped from IDLE or straight out of the last stop bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_load = !fifo_empty;
            end
            TxStart: begin
                if (tx_cnt_q == BitMax) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxData: begin
                if (tx_cnt_q == BitMax) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LastBit) begin
                        if (HasParity) begin
                            tx_state_d = TxParity;
                            txd_d      = tx_par_q;
                        end else begin
                            tx_state_d = TxStop;
                            tx_stop_d  = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxParity: begin
                if (tx_cnt_q == BitMax) begin
                    tx_cnt_d   = '0;
                    tx_stop_d  = 1'b0;
                    tx_state_d = TxStop;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxStop: begin
                if (tx_cnt_q == BitMax) begin
                    tx_cnt_d = '0;
                    if (tx_stop_q == StopLast) begin
                        tx_state_d = TxIdle;
                        tx_load    = !fifo_empty;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
        if (tx_load) begin
            tx_shift_d = fifo_dout;
            tx_par_d   = parity_bit(fifo_dout, PARITY);
            tx_cnt_d   = '0;
            tx_state_d = TxStart;
            txd_d      = 1'b0;
        end
        fifo_pop = tx_load;
    end

    assign uart_txd = txd_q;
    assign tx_busy  = (tx_state_q != TxIdle);

endmodule

// File: tb/tb_uart_fifo_echo.sv
// Directed bench for uart_fifo_echo: table of single frames plus latency, break, glitch,
// burst, overflow and mid-frame reset sequences.
module tb_uart_fifo_echo;

    localparam int unsigned FREQ = 1000000;
    localparam int unsigned BPS  = 100000;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rxd = 1'b1;
    logic       txd;
    logic [4:0] fifo_count;
    logic       tx_busy, perr, ferr, ovf;

    logic       rxd2 = 1'b1;
    logic       txd2;
    logic [1:0] fc2;
    logic       busy2, perr2, ferr2, ovf2;

    int n_vec = 0;
    int n_bad = 0;
    int perr_n = 0, ferr_n = 0, ovf_n = 0;
    int perr2_n = 0, ferr2_n = 0, ovf2_n = 0, fc2_max = 0;

    logic [7:0] echo_q[$];
    bit         echo_ok_q[$];
    logic [7:0] echo2_q[$];

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        int         exp_echo;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    uart_fifo_echo #(
        .FREQ(FREQ), .BPS(BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) u_dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .uart_rxd   (rxd),
        .uart_txd   (txd),
        .fifo_count (fifo_count),
        .tx_busy    (tx_busy),
        .parity_err (perr),
        .frame_err  (ferr),
        .overflow   (ovf)
    );

    // Small-FIFO, two-stop-bit instance: TX is slower than RX, so it can overflow
    uart_fifo_echo #(
        .FREQ(FREQ), .BPS(BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)
    ) u_ovf (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .uart_rxd   (rxd2),
        .uart_txd   (txd2),
        .fifo_count (fc2),
        .tx_busy    (busy2),
        .parity_err (perr2),
        .frame_err  (ferr2),
        .overflow   (ovf2)
    );

    initial forever #5 clk = ~clk;

    // Pulse counters and FIFO high-water mark
    always @(negedge clk) begin
        if (perr)  perr_n++;
        if (ferr)  ferr_n++;
        if (ovf)   ovf_n++;
        if (perr2) perr2_n++;
        if (ferr2) ferr2_n++;
        if (ovf2)  ovf2_n++;
        if (int'(fc2) > fc2_max) fc2_max = int'(fc2);
    end

    // Decode frames on the main TX line (10 clk per bit, even parity)
    initial begin : mon1
        logic [7:0] b;
        logic       p, s;
        forever begin
            @(negedge clk);
            if (!sys_rst && txd === 1'b0) begin
                repeat (5) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = txd;
                end
                repeat (10) @(negedge clk);
                p = txd;
                repeat (10) @(negedge clk);
                s = txd;
                echo_q.push_back(b);
                echo_ok_q.push_back((p == ^b) && (s == 1'b1));
            end
        end
    end

    // Decode frames on the overflow instance's TX line
    initial begin : mon2
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!sys_rst && txd2 === 1'b0) begin
                repeat (5) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = txd2;
                end
                repeat (20) @(negedge clk);
                echo2_q.push_back(b);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_line(input bit to2, input logic v);
        if (to2) rxd2 = v;
        else     rxd  = v;
    endtask

    // Drive one 11-bit frame; the stop level is held for stop_clks, then the line idles high
    task automatic drive_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                               input int stop_clks, input bit to2);
        logic [10:0] bits;
        bits = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
        @(posedge clk);
        #1 set_line(to2, bits[0]);
        for (int i = 1; i < 11; i++) begin
            repeat (10) @(posedge clk);
            #1 set_line(to2, bits[i]);
        end
        repeat (stop_clks) @(posedge clk);
        #1 set_line(to2, 1'b1);
    endtask

    initial begin : main
        int e0, p0, f0, o0;
        int first_cnt, first_low, cnt1, lows, busy_n;
        bit ordered;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1, 0, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 0, 1, 0};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 1, 0, 0};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1, 0, 0};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 0, 0, 1};
        vecs[5] = '{8'h81, 1'b0, 1'b0, 1, 0, 0};
        vecs[6] = '{8'h7E, 1'b1, 1'b1, 0, 0, 1};  // both wrong: frame error wins
        vecs[7] = '{8'h01, 1'b0, 1'b0, 1, 0, 0};

        // Reset state
        #12;
        check("rst_txd", int'(txd), 1);
        check("rst_count", int'(fifo_count), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_pulses", int'({perr, ferr, ovf}), 0);
        #20 sys_rst = 1'b0;
        repeat (5) @(posedge clk);

        // Latency of the first echo for 0xA5
        first_cnt = 0; first_low = 0; cnt1 = 0;
        e0 = echo_q.size();
        fork
            drive_frame(8'hA5, 1'b0, 1'b0, 10, 1'b0);
            begin
                @(posedge clk);
                for (int n = 1; n <= 400; n++) begin
                    @(negedge clk);
                    if (fifo_count != 0 && first_cnt == 0) first_cnt = n;
                    if (fifo_count == 5'd1) cnt1++;
                    if (txd == 1'b0 && first_low == 0) first_low = n;
                end
            end
        join
        check("lat_push", first_cnt, 109);
        check("lat_count1_cycles", cnt1, 1);
        check("lat_txd_low", first_low, 110);
        check("lat_echo_cnt", echo_q.size() - e0, 1);
        if (echo_q.size() > e0) begin
            check("lat_echo_data", int'(echo_q[e0]), 'hA5);
            check("lat_echo_frame", int'(echo_ok_q[e0]), 1);
        end

        // Table of single frames
        for (int v = 0; v < 8; v++) begin
            e0 = echo_q.size(); p0 = perr_n; f0 = ferr_n; o0 = ovf_n;
            drive_frame(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop, 10, 1'b0);
            repeat (150) @(posedge clk);
            check($sformatf("v%0d_echo_cnt", v), echo_q.size() - e0, vecs[v].exp_echo);
            check($sformatf("v%0d_perr", v), perr_n - p0, vecs[v].exp_perr);
            check($sformatf("v%0d_ferr", v), ferr_n - f0, vecs[v].exp_ferr);
            check($sformatf("v%0d_ovf", v), ovf_n - o0, 0);
            check($sformatf("v%0d_count", v), int'(fifo_count), 0);
            if (vecs[v].exp_echo == 1 && echo_q.size() > e0) begin
                check($sformatf("v%0d_echo_data", v), int'(echo_q[e0]), int'(vecs[v].data));
                check($sformatf("v%0d_echo_frame", v), int'(echo_ok_q[e0]), 1);
            end
        end

        // Break: stop bit low and line held low for 50 bit times
        e0 = echo_q.size(); p0 = perr_n; f0 = ferr_n;
        drive_frame(8'h55, 1'b0, 1'b1, 500, 1'b0);
        repeat (200) @(posedge clk);
        check("break_ferr", ferr_n - f0, 1);
        check("break_perr", perr_n - p0, 0);
        check("break_echo", echo_q.size() - e0, 0);

        // Glitch: 3 clk low is a false start; a following good frame still works
        e0 = echo_q.size(); p0 = perr_n; f0 = ferr_n; o0 = ovf_n;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (50) @(posedge clk);
        check("glitch_pulses", (perr_n - p0) + (ferr_n - f0) + (ovf_n - o0), 0);
        check("glitch_count", int'(fifo_count), 0);
        check("glitch_busy", int'(tx_busy), 0);
        drive_frame(8'h96, 1'b0, 1'b0, 10, 1'b0);
        repeat (150) @(posedge clk);
        check("glitch_echo_cnt", echo_q.size() - e0, 1);
        if (echo_q.size() > e0) check("glitch_echo_data", int'(echo_q[e0]), 'h96);

        // Back-to-back burst 0x00..0x13 on the main instance
        e0 = echo_q.size(); o0 = ovf_n;
        for (int i = 0; i < 20; i++) drive_frame(8'(i), 1'b0, 1'b0, 8, 1'b0);
        repeat (600) @(posedge clk);
        check("burst_echo_cnt", echo_q.size() - e0, 20);
        check("burst_ovf", ovf_n - o0, 0);
        ordered = 1'b1;
        for (int i = 0; i < 20 && e0 + i < echo_q.size(); i++) begin
            if (echo_q[e0 + i] != 8'(i) || !echo_ok_q[e0 + i]) ordered = 1'b0;
        end
        check("burst_in_order", int'(ordered), 1);

        // Overflow: 40 fast frames into the 2-deep, 2-stop-bit instance
        for (int i = 0; i < 40; i++) drive_frame(8'(i), 1'b0, 1'b0, 8, 1'b1);
        repeat (800) @(posedge clk);
        check("ovf_seen", int'(ovf2_n > 0), 1);
        check("ovf_accounting", echo2_q.size() + ovf2_n, 40);
        check("ovf_fifo_max", fc2_max, 2);
        check("ovf_other_errs", perr2_n + ferr2_n, 0);
        check("ovf_drained", int'({busy2, fc2}), 0);
        ordered = (echo2_q.size() > 0) && (echo2_q[0] == 8'h00);
        for (int i = 1; i < echo2_q.size(); i++) begin
            if (echo2_q[i] <= echo2_q[i-1]) ordered = 1'b0;
        end
        check("ovf_in_order", int'(ordered), 1);

        // Reset in the middle of TX data bit 4 of 0xA5 (bit value 0)
        drive_frame(8'hA5, 1'b0, 1'b0, 10, 1'b0);
        repeat (54) @(negedge clk);
        check("pre_rst_bit4", int'(txd), 0);
        check("pre_rst_busy", int'(tx_busy), 1);
        #2 sys_rst = 1'b1;
        #1;
        check("rst_mid_txd", int'(txd), 1);
        check("rst_mid_busy", int'(tx_busy), 0);
        check("rst_mid_count", int'(fifo_count), 0);
        check("rst_mid_pulses", int'({perr, ferr, ovf}), 0);
        repeat (3) @(negedge clk);
        #2 sys_rst = 1'b0;
        lows = 0; busy_n = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (txd == 1'b0) lows++;
            if (tx_busy) busy_n++;
        end
        check("post_rst_txd_lows", lows, 0);
        check("post_rst_busy", busy_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
